// File: rtl/pdt_sum_diff_seq_if.sv
// Request/response and read-port bundle for the sequential sum/difference product unit.
interface pdt_sum_diff_seq_if #(
  parameter int W  = 16,
  parameter int AW = 3
);
  logic            start;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic [AW-1:0]   waddr;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  o;
  logic [AW-1:0]   raddr;
  logic [2*W-1:0]  rdata;

  modport master (
    output start, x, y, waddr, raddr,
    input  busy, done, o, rdata
  );

  modport slave (
    input  start, x, y, waddr, raddr,
    output busy, done, o, rdata
  );
endinterface

// File: rtl/pdt_sum_diff_seq.sv
// Multi-cycle P = (X+Y)*(X-Y) via radix-2 shift-add, results stored in an addressable bank.
// Optional macro PDT_EARLY_TERM_EN: leave MUL as soon as the remaining multiplier bits are zero.
module pdt_sum_diff_seq #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  pdt_sum_diff_seq_if.slave  bus
);

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WB
  } state_t;

  state_t          state, state_nxt;
  logic            load, step, wb, last;
  logic [W-1:0]    sum, diff;
  logic [2*W-1:0]  mcand, acc, o_q;
  logic [W-1:0]    mplr;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   waddr_q;
  logic            done_q;
  logic [2*W-1:0]  bank [DEPTH];

  // Carry and borrow fall off the top: both operands of the product are W-bit modular values.
  assign sum  = bus.x + bus.y;
  assign diff = bus.x - bus.y;

`ifdef PDT_EARLY_TERM_EN
  assign last = (cnt == CNT_LAST) || (mplr[W-1:1] == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinationally written signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_MUL;
      S_MUL:   if (last)      state_nxt = S_WB;
      S_WB:                   state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    wb       = 1'b0;
    bus.busy = 1'b1;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        load     = bus.start;
      end
      S_MUL:   step = 1'b1;
      S_WB:    wb   = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      waddr_q <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      if (load) begin
        mcand   <= {{W{1'b0}}, sum};
        mplr    <= diff;
        waddr_q <= bus.waddr;
        acc     <= '0;
        cnt     <= '0;
      end
      if (step) begin
        if (mplr[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        cnt   <= cnt + 1'b1;
      end
      if (wb) o_q <= acc;
      done_q <= wb;
    end
  end

  // NOTE: the bank must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (wb) begin
      bank[waddr_q] <= acc;
    end
  end

  assign bus.done  = done_q;
  assign bus.o     = o_q;
  assign bus.rdata = bank[bus.raddr];

endmodule

// File: tb/tb_pdt_sum_diff_seq.sv
// Directed bench for pdt_sum_diff_seq: vector table plus reset, ignored-START and back-to-back sequences.
module tb_pdt_sum_diff_seq;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pdt_sum_diff_seq_if #(.W(W), .AW(AW)) bus ();

  pdt_sum_diff_seq #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [AW-1:0]  waddr;
    logic [2*W-1:0] exp_o;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from accept to the DONE-raising edge.
  function automatic int exp_lat(input logic [W-1:0] diff);
`ifdef PDT_EARLY_TERM_EN
    int h;
    h = -1;
    for (int i = 0; i < W; i++) if (diff[i]) h = i;
    return (h < 0) ? 2 : h + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic read_bank(input logic [AW-1:0] a, output logic [2*W-1:0] d);
    bus.raddr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic run_op(input string name, input vec_t v);
    int n;
    logic [2*W-1:0] rd;
    logic [W-1:0]   diff;
    diff      = v.x - v.y;
    bus.start = 1'b1;
    bus.x     = v.x;
    bus.y     = v.y;
    bus.waddr = v.waddr;
    tick();
    bus.start = 1'b0;
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
    bus.waddr = AW'($urandom);
    check({name, " busy_after_accept"}, 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat(diff)));
    check({name, " o"}, 64'(bus.o), 64'(v.exp_o));
    check({name, " busy_in_done"}, 64'(bus.busy), 64'd0);
    read_bank(v.waddr, rd);
    check({name, " rdata"}, 64'(rd), 64'(v.exp_o));
    tick();
    check({name, " done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n, ndone, t0, t1;
    logic drop;
    logic [2*W-1:0] rd, prev_rd;

    vecs[0] = '{x: 16'd5,      y: 16'd3,      waddr: 3'd2, exp_o: 32'h0000_0010};
    vecs[1] = '{x: 16'd3,      y: 16'd5,      waddr: 3'd4, exp_o: 32'h0007_FFF0};
    vecs[2] = '{x: 16'hFFFF,   y: 16'h0000,   waddr: 3'd5, exp_o: 32'hFFFE_0001};
    vecs[3] = '{x: 16'h1234,   y: 16'h0034,   waddr: 3'd7, exp_o: 32'h014B_5000};
    vecs[4] = '{x: 16'd9,      y: 16'd9,      waddr: 3'd6, exp_o: 32'h0000_0000};
    vecs[5] = '{x: 16'd100,    y: 16'd50,     waddr: 3'd0, exp_o: 32'h0000_1D4C};
    vecs[6] = '{x: 16'd7,      y: 16'd2,      waddr: 3'd1, exp_o: 32'h0000_002D};

    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.waddr = '0;
    bus.raddr = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset o", 64'(bus.o), 64'd0);
    for (int a = 0; a < DEPTH; a++) begin
      read_bank(AW'(a), rd);
      check($sformatf("reset bank[%0d]", a), 64'(rd), 64'd0);
    end

    for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Carry wrap (SUM=0) overwrites entry 7; a START pulse mid-operation must be dropped.
    bus.start = 1'b1;
    bus.x     = 16'hFFFF;
    bus.y     = 16'h0001;
    bus.waddr = 3'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.start = 1'b1;
    bus.x     = 16'd5;
    bus.y     = 16'd3;
    bus.waddr = 3'd3;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("ignored_start done_count", 64'(ndone), 64'd1);
    check("carry_wrap o", 64'(bus.o), 64'd0);
    read_bank(3'd7, rd);
    check("carry_wrap bank[7]", 64'(rd), 64'd0);
    read_bank(3'd3, rd);
    check("ignored_start bank[3]", 64'(rd), 64'd0);

    // Asynchronous reset mid-MUL aborts the operation and clears the bank.
    bus.start = 1'b1;
    bus.x     = 16'd5;
    bus.y     = 16'd3;
    bus.waddr = 3'd3;
    tick();
    bus.start = 1'b0;
    tick();
    check("pre_abort busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    tick();
    tick();
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("abort no_done", 64'(ndone), 64'd0);
    for (int a = 0; a < DEPTH; a++) begin
      read_bank(AW'(a), rd);
      check($sformatf("abort bank[%0d]", a), 64'(rd), 64'd0);
    end

    // Back-to-back with START held: the second request is taken on the edge that ends the DONE cycle.
    bus.start = 1'b1;
    bus.x     = 16'd5;
    bus.y     = 16'd3;
    bus.waddr = 3'd0;
    bus.raddr = 3'd1;
    tick();
    bus.x     = 16'd7;
    bus.y     = 16'd2;
    bus.waddr = 3'd1;
    n     = 0;
    ndone = 0;
    t0    = 0;
    t1    = 0;
    drop  = 1'b0;
    while (ndone < 2 && n < 100) begin
      prev_rd = bus.rdata;
      tick();
      n++;
      if (drop) bus.start = 1'b0;
      if (bus.done) begin
        if (ndone == 0) begin
          t0   = n;
          drop = 1'b1;
          check("b2b first o", 64'(bus.o), 64'd16);
        end else begin
          t1 = n;
          check("b2b second o", 64'(bus.o), 64'd45);
          check("b2b rd during wb", 64'(prev_rd), 64'd0);
          check("b2b rd after wb", 64'(bus.rdata), 64'd45);
        end
        ndone++;
      end
    end
    bus.start = 1'b0;
    check("b2b done_count", 64'(ndone), 64'd2);
    check("b2b first latency", 64'(t0), 64'(exp_lat(16'd2)));
    check("b2b done spacing", 64'(t1 - t0), 64'(exp_lat(16'd5) + 1));
    read_bank(3'd0, rd);
    check("b2b bank[0]", 64'(rd), 64'd16);
    read_bank(3'd1, rd);
    check("b2b bank[1]", 64'(rd), 64'd45);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
